// File: rtl/conv_layer_input_interface_param.sv
// Streams a channel-major image from an async-read pixel memory as window-column vectors
// for an OUT_W-lane PE array. Optional zero padding is enabled by defining CONV_IF_ZERO_PAD_EN.
module conv_layer_input_interface_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_W     = 8,
  parameter int IMAGE_H     = 8,
  parameter int CHANNELS    = 1,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int ADDR_WIDTH  = 6,
`ifdef CONV_IF_ZERO_PAD_EN
  localparam int PAD        = (KERNEL_SIZE - 1) / 2,
`else
  localparam int PAD        = 0,
`endif
  localparam int OUT_W      = (IMAGE_W + 2 * PAD - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_H      = (IMAGE_H + 2 * PAD - KERNEL_SIZE) / STRIDE + 1,
  localparam int CH_W       = $clog2(CHANNELS) + 1,
  localparam int ROW_W      = $clog2(OUT_H) + 1,
  localparam int K_W        = $clog2(KERNEL_SIZE) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       pixel_in,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [OUT_W*DATA_WIDTH-1:0] out_kernel_port,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_W-1:0]             out_ch,
  output logic [ROW_W-1:0]            out_row,
  output logic [K_W-1:0]              kernel_row,
  output logic [K_W-1:0]              kernel_col,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int BUF_W = IMAGE_W + 2 * PAD;
  localparam int COL_W = $clog2(IMAGE_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state, w_state_nx;
  logic [CH_W-1:0]           r_ch, w_ch_nx;
  logic [ROW_W-1:0]          r_row, w_row_nx;
  logic [K_W-1:0]            r_kr, w_kr_nx;
  logic [K_W-1:0]            r_kc, w_kc_nx;
  logic [COL_W-1:0]          r_col, w_col_nx;
  logic [ADDR_WIDTH-1:0]     r_addr, w_addr_nx;
  logic [DATA_WIDTH-1:0]     r_buf [BUF_W];
  logic [DATA_WIDTH-1:0]     w_buf_nx [BUF_W];
  logic [OUT_W*DATA_WIDTH-1:0] r_out, w_vec_nx;
  logic                      r_valid, r_busy, r_frame_done;
  logic                      w_frame_end;

  function automatic int f_src_row(input int row, input int kr);
    return row * STRIDE + kr - PAD;
  endfunction

  function automatic logic f_row_ok(input int src);
    return (src >= 0) && (src < IMAGE_H);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_base(input int ch, input int src);
    return ADDR_WIDTH'(ch * IMAGE_H * IMAGE_W + src * IMAGE_W);
  endfunction

  assign mem_addr        = r_addr;
  assign out_kernel_port = r_out;
  assign out_valid       = r_valid;
  assign out_ch          = r_ch;
  assign out_row         = r_row;
  assign kernel_row      = r_kr;
  assign kernel_col      = r_kc;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;

  assign w_frame_end = (r_kr == K_W'(KERNEL_SIZE - 1)) && (r_row == ROW_W'(OUT_H - 1)) &&
                       (r_ch == CH_W'(CHANNELS - 1));

  // State and loop-index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_row   <= '0;
      r_kr    <= '0;
      r_kc    <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ch    <= w_ch_nx;
      r_row   <= w_row_nx;
      r_kr    <= w_kr_nx;
      r_kc    <= w_kc_nx;
      r_col   <= w_col_nx;
    end
  end

  // Next state and loop indices; enable low while busy aborts to IDLE
  always_comb begin
    w_state_nx = r_state;
    w_ch_nx    = r_ch;
    w_row_nx   = r_row;
    w_kr_nx    = r_kr;
    w_kc_nx    = r_kc;
    w_col_nx   = r_col;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_ch_nx    = '0;
          w_row_nx   = '0;
          w_kr_nx    = '0;
          w_kc_nx    = '0;
          w_col_nx   = '0;
          w_state_nx = f_row_ok(f_src_row(0, 0)) ? S_LOAD : S_CLEAR;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_LOAD, S_CLEAR, S_EMIT: begin
        if (!enable) begin
          w_state_nx = S_IDLE;
          w_ch_nx    = '0;
          w_row_nx   = '0;
          w_kr_nx    = '0;
          w_kc_nx    = '0;
          w_col_nx   = '0;
        end else if (r_state == S_LOAD) begin
          if (r_col == COL_W'(IMAGE_W - 1)) begin
            w_state_nx = S_EMIT;
            w_col_nx   = '0;
            w_kc_nx    = '0;
          end else begin
            w_col_nx = r_col + COL_W'(1'b1);
          end
        end else if (r_state == S_CLEAR) begin
          w_state_nx = S_EMIT;
          w_kc_nx    = '0;
        end else if (out_ready) begin
          if (r_kc == K_W'(KERNEL_SIZE - 1)) begin
            w_kc_nx = '0;
            if (r_kr == K_W'(KERNEL_SIZE - 1)) begin
              w_kr_nx = '0;
              if (r_row == ROW_W'(OUT_H - 1)) begin
                w_row_nx = '0;
                if (r_ch == CH_W'(CHANNELS - 1)) begin
                  w_ch_nx = '0;
                end else begin
                  w_ch_nx = r_ch + CH_W'(1'b1);
                end
              end else begin
                w_row_nx = r_row + ROW_W'(1'b1);
              end
            end else begin
              w_kr_nx = r_kr + K_W'(1'b1);
            end
            if (w_frame_end) begin
              w_state_nx = S_DONE;
            end else begin
              w_state_nx = f_row_ok(f_src_row(int'(w_row_nx), int'(w_kr_nx))) ? S_LOAD : S_CLEAR;
            end
          end else begin
            w_kc_nx = r_kc + K_W'(1'b1);
          end
        end else begin
          w_state_nx = S_EMIT;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Read address, row-buffer update and the next output vector
  always_comb begin
    w_addr_nx = r_addr;
    w_buf_nx  = r_buf;
    case (r_state)
      S_IDLE: begin
        if (w_state_nx == S_LOAD) begin
          w_addr_nx = f_base(0, f_src_row(0, 0));
        end else begin
          w_addr_nx = r_addr;
        end
      end
      S_LOAD: begin
        if (w_state_nx == S_IDLE) begin
          w_addr_nx = '0;
        end else begin
          for (int i = 0; i < IMAGE_W; i++) begin
            if (r_col == COL_W'(i)) begin
              w_buf_nx[PAD+i] = pixel_in;
            end else begin
              w_buf_nx[PAD+i] = r_buf[PAD+i];
            end
          end
          // The last column holds its address so mem_addr never runs past the image
          if (w_state_nx == S_LOAD) begin
            w_addr_nx = r_addr + ADDR_WIDTH'(1'b1);
          end else begin
            w_addr_nx = r_addr;
          end
        end
      end
      S_CLEAR: begin
        if (w_state_nx == S_EMIT) begin
          for (int i = 0; i < BUF_W; i++) begin
            w_buf_nx[i] = '0;
          end
        end else begin
          w_addr_nx = '0;
        end
      end
      S_EMIT: begin
        if (w_state_nx == S_LOAD) begin
          w_addr_nx = f_base(int'(w_ch_nx), f_src_row(int'(w_row_nx), int'(w_kr_nx)));
        end else if (w_state_nx == S_IDLE) begin
          w_addr_nx = '0;
        end else begin
          w_addr_nx = r_addr;
        end
      end
      default: w_addr_nx = r_addr;
    endcase
    // Lane j picks buffer column j*STRIDE+kc through an AND-OR mux over kc
    w_vec_nx = '0;
    for (int j = 0; j < OUT_W; j++) begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        w_vec_nx[(OUT_W-j)*DATA_WIDTH-1 -: DATA_WIDTH] =
          w_vec_nx[(OUT_W-j)*DATA_WIDTH-1 -: DATA_WIDTH] |
          ({DATA_WIDTH{w_kc_nx == K_W'(k)}} & w_buf_nx[j*STRIDE+k]);
      end
    end
  end

  // Datapath and status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < BUF_W; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_addr <= w_addr_nx;
      for (int i = 0; i < BUF_W; i++) begin
        r_buf[i] <= w_buf_nx[i];
      end
      if (w_state_nx == S_EMIT) begin
        r_out <= w_vec_nx;
      end else begin
        r_out <= r_out;
      end
      r_valid      <= (w_state_nx == S_EMIT);
      r_busy       <= (w_state_nx == S_LOAD) || (w_state_nx == S_CLEAR) || (w_state_nx == S_EMIT);
      r_frame_done <= (w_state_nx == S_DONE);
    end
  end

endmodule

// File: doc/conv_layer_input_interface_param.md
Name: conv_layer_input_interface_param

Overview:
- Parametrised successor to the fixed 8x8 / 3x3 / 6-lane conv input interface.
- Streams a multi-channel image from an asynchronous-read pixel memory (ROM/LUTRAM, data valid same cycle as address).
- Presents one window-column vector per handshake to a parallel array of OUT_W kernel PEs; configurable kernel size and stride, with valid/ready backpressure.
- Sits between the feature-map memory and the conv_layer PE array.

Parameters:
- DATA_WIDTH, 32, pixel width (IEEE-754 single).
- IMAGE_W, 8, image columns.
- IMAGE_H, 8, image rows.
- CHANNELS, 1, input channels, stored channel-major.
- KERNEL_SIZE, 3, square kernel side K.
- STRIDE, 1, window step in rows and columns.
- ADDR_WIDTH, 6, memory address width; must satisfy 2^ADDR_WIDTH >= CHANNELS*IMAGE_H*IMAGE_W.
- Derived localparams, without ZERO_PAD_EN:
  - OUT_W = (IMAGE_W-K)/STRIDE+1
  - OUT_H = (IMAGE_H-K)/STRIDE+1

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  level; high in IDLE starts a frame; low mid-frame aborts.
- pixel_in  in  DATA_WIDTH  memory read data for mem_addr, same cycle.
- mem_addr  out  ADDR_WIDTH  registered read address.
- out_kernel_port  out  OUT_W*DATA_WIDTH  lane j at bits [(OUT_W-j)*DATA_WIDTH-1 -: DATA_WIDTH]; lane 0 is MSB.
- out_valid  out  1  out_kernel_port is valid.
- out_ready  in  1  PE array accepts; transfer occurs when out_valid && out_ready.
- out_ch  out  $clog2(CHANNELS)+1  channel of current vector.
- out_row  out  $clog2(OUT_H)+1  output row index.
- kernel_row  out  $clog2(K)+1  kr of current vector.
- kernel_col  out  $clog2(K)+1  kc of current vector.
- busy  out  1  high in LOAD or EMIT.
- frame_done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (async, rst=1): state IDLE; mem_addr=0; out_kernel_port=0; row buffer=0; out_valid=0; busy=0; frame_done=0; all indices 0. Reset mid-frame discards all progress.
- Memory layout: addr = ch*IMAGE_H*IMAGE_W + row*IMAGE_W + col.
- Loop order, outermost first: ch, out_row r, kr; then kc inside EMIT.
- Row buffer buf[0..IMAGE_W-1].
- IDLE:
  - enable=1 sampled -> LOAD; mem_addr = base of (ch=0, row=0).
  - frame_done=0.
- LOAD: IMAGE_W cycles. Cycle i captures pixel_in into buf[i], with mem_addr = base(ch, r*STRIDE+kr)+i. After the last capture -> EMIT with kc=0.
- EMIT:
  - out_kernel_port lane j = buf[j*STRIDE+kc], registered; out_valid=1.
  - On transfer: kc++.
  - When kc==K-1 transfers: kr++ and -> LOAD. If kr wraps: r++. If r wraps: ch++. If ch wraps: -> DONE.
  - out_ready=0 holds out_kernel_port, out_valid and all indices stable.
- DONE: frame_done=1 for one cycle -> IDLE. A new frame starts only if enable=1 is seen in IDLE.
- Latency: first out_valid on the (IMAGE_W+1)th rising edge after enable is sampled in IDLE.
- Transfers per frame: CHANNELS*OUT_H*K*K.
- enable=0 while busy: next edge -> IDLE, out_valid=0, indices cleared; no frame_done.
- mem_addr never exceeds CHANNELS*IMAGE_H*IMAGE_W-1.
- Partial stride remainders are discarded: trailing columns/rows not covered by a full window are unused.

Optional Feature:
- Macro: CONV_IF_ZERO_PAD_EN.
- Defined: zero padding P=(K-1)/2 on all sides.
  - OUT_W=(IMAGE_W+2P-K)/STRIDE+1; OUT_H likewise.
  - Buffer width IMAGE_W+2P; edge entries are constant 0.
  - Source row r*STRIDE+kr-P out of range: LOAD is replaced by one cycle that clears the buffer, with no memory reads and mem_addr unchanged.
- Undefined: no padding, no clear cycle, behaviour as above.

Test Plan:
- Defaults; ROM[a]=a; out_ready=1; enable at t0:
  - first out_valid 9 edges later with lanes {0,1,2,3,4,5}, kr=0, kc=0;
  - then kc=1 {1..6}, kc=2 {2..7}; kr=1 kc=0 {8..13};
  - 54 transfers total, then one frame_done pulse.
- STRIDE=2: OUT_W=3, OUT_H=3.
  - First vectors {0,2,4}, {1,3,5}, {2,4,6}.
  - out_row=1, kr=0 starts at {16,18,20}.
- Backpressure: drop out_ready for 5 cycles at the 4th vector ({8..13}); vector and indices stay stable; no transfer lost or duplicated; total count still 54.
- CHANNELS=2, ADDR_WIDTH=7: the 55th transfer has out_ch=1 and lanes {64..69}; 108 transfers total; frame_done once.
- Abort and reset:
  - enable dropped mid-LOAD -> IDLE next edge, out_valid=0, no frame_done.
  - rst pulsed mid-EMIT -> all outputs 0 immediately.
  - Re-enable restarts from lanes {0..5}.
- CONV_IF_ZERO_PAD_EN, defaults (8 lanes):
  - r=0, kr=0: all-zero vector, with no mem_addr change.
  - kr=1, kc=0: {0,0,1,2,3,4,5,6}.
  - kr=1, kc=2: {1,2,3,4,5,6,7,0}.
  - 72 transfers total.
